// File: rtl/ame_pkg.sv
// Shared definitions for the affine motion-estimation solver datapath.
package ame_pkg;

  localparam int unsigned AME_NUM_RESULTS    = 6;
  localparam int unsigned AME_COMP_DATA_BITS = 64;

  localparam logic [1:0] AXI_BURST_INCR = 2'h1;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'h0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_RESP  = 2'd2
  } ame_wr_state_t;

  typedef logic [AME_NUM_RESULTS-1:0][AME_COMP_DATA_BITS-1:0] ame_result_t;

endpackage

// File: rtl/ame_result_writer.sv
// Writes the solved affine parameter vector to memory as a single AXI4 INCR burst
// and reports completion / write-response error to the register front end.
module ame_result_writer
  import ame_pkg::*;
#(
  parameter int unsigned COMP_DATA_BITS = 64,
  parameter int unsigned ADDR_BITS      = 32
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic                                            start_i,
  input  logic                                            affine_param6_i,
  input  logic [ADDR_BITS-1:0]                            base_addr_i,
  input  logic [AME_NUM_RESULTS-1:0][COMP_DATA_BITS-1:0]  comp_data_i,
  output logic                                            busy_o,
  output logic                                            done_o,
  output logic                                            err_o,
  output logic [ADDR_BITS-1:0]                            m_axi_awaddr,
  output logic [7:0]                                      m_axi_awlen,
  output logic [2:0]                                      m_axi_awsize,
  output logic [1:0]                                      m_axi_awburst,
  output logic                                            m_axi_awvalid,
  input  logic                                            m_axi_awready,
  output logic [COMP_DATA_BITS-1:0]                       m_axi_wdata,
  output logic [COMP_DATA_BITS/8-1:0]                     m_axi_wstrb,
  output logic                                            m_axi_wlast,
  output logic                                            m_axi_wvalid,
  input  logic                                            m_axi_wready,
  input  logic [1:0]                                      m_axi_bresp,
  input  logic                                            m_axi_bvalid,
  output logic                                            m_axi_bready
);

  ame_wr_state_t                                   state_q;
  logic [AME_NUM_RESULTS-1:0][COMP_DATA_BITS-1:0]  data_q;
  logic [2:0]                                      first_q;
  logic [2:0]                                      beat_q;
  logic [2:0]                                      last_beat_q;
  logic                                            aw_done_q;
  logic                                            w_done_q;

  logic                 aw_hs;
  logic                 w_hs;
  logic                 w_last_hs;
  logic [2:0]           acc_first;
  logic [2:0]           nxt_idx;
  logic [ADDR_BITS-1:0] acc_addr;
  logic                 unused_base;

  always_comb begin
    aw_hs       = m_axi_awvalid && m_axi_awready;
    w_hs        = m_axi_wvalid && m_axi_wready;
    w_last_hs   = w_hs && m_axi_wlast;
    acc_first   = affine_param6_i ? 3'd0 : 3'd2;
    nxt_idx     = first_q + beat_q + 3'd1;
    // Base forced to 64-byte alignment so a 48-byte burst never crosses 4 KB.
    acc_addr    = {base_addr_i[ADDR_BITS-1:6], 6'b0} + ADDR_BITS'({acc_first, 3'b000});
    unused_base = ^base_addr_i[5:0];
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign m_axi_bready = (state_q == ST_RESP);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      data_q        <= '0;
      first_q       <= '0;
      beat_q        <= '0;
      last_beat_q   <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_awlen   <= '0;
      m_axi_awsize  <= '0;
      m_axi_awburst <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_wlast   <= 1'b0;
      m_axi_wvalid  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            data_q        <= comp_data_i;
            first_q       <= acc_first;
            beat_q        <= '0;
            last_beat_q   <= affine_param6_i ? 3'd5 : 3'd3;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
            err_o         <= 1'b0;
            m_axi_awaddr  <= acc_addr;
            m_axi_awlen   <= affine_param6_i ? 8'd5 : 8'd3;
            m_axi_awsize  <= 3'h3;
            m_axi_awburst <= AXI_BURST_INCR;
            m_axi_awvalid <= 1'b1;
            m_axi_wdata   <= comp_data_i[acc_first];
            m_axi_wstrb   <= '1;
            m_axi_wlast   <= 1'b0;
            m_axi_wvalid  <= 1'b1;
            state_q       <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done_q     <= 1'b1;
          end
          if (w_hs) begin
            if (m_axi_wlast) begin
              m_axi_wvalid <= 1'b0;
              m_axi_wlast  <= 1'b0;
              w_done_q     <= 1'b1;
            end else begin
              beat_q      <= beat_q + 3'd1;
              m_axi_wdata <= data_q[nxt_idx];
              m_axi_wlast <= ((beat_q + 3'd1) == last_beat_q);
            end
          end
          if ((aw_done_q || aw_hs) && (w_done_q || w_last_hs)) begin
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (m_axi_bvalid) begin
            done_o  <= 1'b1;
            if (m_axi_bresp != AXI_RESP_OKAY) begin
              err_o <= 1'b1;
            end
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ame_result_writer.sv
// Directed bench for ame_result_writer with a cycle-level AXI write slave model.
module tb_ame_result_writer;
  import ame_pkg::*;

  logic                     clk_i;
  logic                     rst_i;
  logic                     start_i;
  logic                     affine_param6_i;
  logic [31:0]              base_addr_i;
  ame_result_t              comp_data_i;
  logic                     busy_o;
  logic                     done_o;
  logic                     err_o;
  logic [31:0]              m_axi_awaddr;
  logic [7:0]               m_axi_awlen;
  logic [2:0]               m_axi_awsize;
  logic [1:0]               m_axi_awburst;
  logic                     m_axi_awvalid;
  logic                     m_axi_awready;
  logic [63:0]              m_axi_wdata;
  logic [7:0]               m_axi_wstrb;
  logic                     m_axi_wlast;
  logic                     m_axi_wvalid;
  logic                     m_axi_wready;
  logic [1:0]               m_axi_bresp;
  logic                     m_axi_bvalid;
  logic                     m_axi_bready;

  int n_tests = 0;
  int n_fail  = 0;

  ame_result_writer #(
    .COMP_DATA_BITS(64),
    .ADDR_BITS     (32)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .affine_param6_i(affine_param6_i),
    .base_addr_i    (base_addr_i),
    .comp_data_i    (comp_data_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .m_axi_awaddr   (m_axi_awaddr),
    .m_axi_awlen    (m_axi_awlen),
    .m_axi_awsize   (m_axi_awsize),
    .m_axi_awburst  (m_axi_awburst),
    .m_axi_awvalid  (m_axi_awvalid),
    .m_axi_awready  (m_axi_awready),
    .m_axi_wdata    (m_axi_wdata),
    .m_axi_wstrb    (m_axi_wstrb),
    .m_axi_wlast    (m_axi_wlast),
    .m_axi_wvalid   (m_axi_wvalid),
    .m_axi_wready   (m_axi_wready),
    .m_axi_bresp    (m_axi_bresp),
    .m_axi_bvalid   (m_axi_bvalid),
    .m_axi_bready   (m_axi_bready)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic idle_check(input int ncyc, input logic exp_err);
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk_i); #1;
      start_i       = 1'b0;
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      @(negedge clk_i);
      check("idle_awvalid", 64'(m_axi_awvalid), 64'(0));
      check("idle_wvalid",  64'(m_axi_wvalid),  64'(0));
      check("idle_done",    64'(done_o),        64'(0));
      check("idle_busy",    64'(busy_o),        64'(0));
      check("idle_err",     64'(err_o),         64'(exp_err));
    end
  endtask

  // Called right after a negedge; start is presented in that cycle (cycle 0).
  task automatic run_burst(input logic p6, input logic [31:0] base, input logic [31:0] exp_addr,
                           input ame_result_t words, input bit stall, input bit aw_after_w,
                           input logic [1:0] bresp, input int b_delay, input bit glitch,
                           input int rst_beat, input int exp_done);
    int  n, first, cyc, beats, aw_seen, w_stall, aw_stall, b_wait;
    bit  b_done, fin, resp_glitched, abort, finished;
    n = p6 ? 6 : 4;
    first = p6 ? 0 : 2;
    cyc = 0; beats = 0; aw_seen = 0; b_wait = b_delay;
    b_done = 0; resp_glitched = 0; abort = 0; finished = 0;
    w_stall  = stall ? int'($urandom_range(5, 0)) : 0;
    aw_stall = stall ? int'($urandom_range(5, 0)) : 0;

    start_i         = 1'b1;
    affine_param6_i = p6;
    base_addr_i     = base;
    comp_data_i     = words;
    m_axi_awready   = 1'b0;
    m_axi_wready    = 1'b0;
    m_axi_bvalid    = 1'b0;
    m_axi_bresp     = bresp;

    for (int t = 0; t < 300; t++) begin
      @(posedge clk_i); #1;
      cyc++;
      start_i = glitch && (cyc == 3);
      if (glitch) begin
        comp_data_i     = ~words;
        affine_param6_i = ~p6;
        base_addr_i     = ~base;
      end
      if (w_stall > 0) begin
        m_axi_wready = 1'b0;
        w_stall--;
      end else begin
        m_axi_wready = 1'b1;
      end
      if (aw_after_w && beats < n) begin
        m_axi_awready = 1'b0;
      end else if (aw_stall > 0) begin
        m_axi_awready = 1'b0;
        aw_stall--;
      end else begin
        m_axi_awready = 1'b1;
      end
      m_axi_bvalid = 1'b0;
      if (aw_seen == 1 && beats == n && !b_done) begin
        if (b_wait > 0) begin
          b_wait--;
          if (glitch && !resp_glitched) begin
            start_i = 1'b1;
            resp_glitched = 1;
          end
        end else begin
          m_axi_bvalid = 1'b1;
        end
      end

      @(negedge clk_i);
      fin = b_done;
      if (cyc == 1) begin
        check("busy_at_c1", 64'(busy_o), 64'(1));
      end
      check("busy",    64'(busy_o),        64'(!fin));
      check("awvalid", 64'(m_axi_awvalid), 64'(aw_seen == 0 && !fin));
      if (m_axi_awvalid) begin
        check("awaddr",  64'(m_axi_awaddr),  64'(exp_addr));
        check("awlen",   64'(m_axi_awlen),   64'(n - 1));
        check("awsize",  64'(m_axi_awsize),  64'(3));
        check("awburst", 64'(m_axi_awburst), 64'(1));
      end
      check("wvalid", 64'(m_axi_wvalid), 64'(beats < n && !fin));
      if (m_axi_wvalid && beats < n) begin
        check("wdata", m_axi_wdata,        words[first + beats]);
        check("wlast", 64'(m_axi_wlast),   64'(beats == n - 1));
        check("wstrb", 64'(m_axi_wstrb),   64'hFF);
      end
      check("bready", 64'(m_axi_bready), 64'(aw_seen == 1 && beats == n && !fin));
      check("done",   64'(done_o),       64'(fin));
      check("err",    64'(err_o),        64'(fin && bresp != 2'b00));
      if (fin && exp_done >= 0) begin
        check("done_cycle", 64'(cyc), 64'(exp_done));
      end

      if (m_axi_awvalid && m_axi_awready) begin
        aw_seen++;
        aw_stall = stall ? int'($urandom_range(5, 0)) : 0;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        beats++;
        w_stall = stall ? int'($urandom_range(5, 0)) : 0;
      end
      if (m_axi_bvalid && m_axi_bready) b_done = 1;

      if (fin) begin
        finished = 1;
        break;
      end
      if (rst_beat > 0 && beats == rst_beat) begin
        abort = 1;
        break;
      end
    end

    if (abort) begin
      @(posedge clk_i); #1;
      rst_i         = 1'b1;
      start_i       = 1'b0;
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      m_axi_bvalid  = 1'b0;
      @(negedge clk_i);
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      @(negedge clk_i);
      check("rst_awvalid", 64'(m_axi_awvalid), 64'(0));
      check("rst_wvalid",  64'(m_axi_wvalid),  64'(0));
      check("rst_bready",  64'(m_axi_bready),  64'(0));
      check("rst_busy",    64'(busy_o),        64'(0));
      check("rst_done",    64'(done_o),        64'(0));
    end else if (!finished) begin
      check("burst_timeout", 64'(0), 64'(1));
    end else begin
      check("beat_count", 64'(beats),   64'(n));
      check("aw_count",   64'(aw_seen), 64'(1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ame_result_t xw, rw;
    for (int k = 0; k < 6; k++) xw[k] = 64'h1111_1111_1111_1111 * 64'(k + 1);

    rst_i = 1'b1; start_i = 1'b0; affine_param6_i = 1'b0; base_addr_i = '0;
    comp_data_i = '0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bresp = 2'b00; m_axi_bvalid = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_awaddr",  64'(m_axi_awaddr),  64'(0));
    check("rst_awlen",   64'(m_axi_awlen),   64'(0));
    check("rst_awsize",  64'(m_axi_awsize),  64'(0));
    check("rst_awburst", 64'(m_axi_awburst), 64'(0));
    check("rst_awvalid", 64'(m_axi_awvalid), 64'(0));
    check("rst_wdata",   m_axi_wdata,        64'(0));
    check("rst_wstrb",   64'(m_axi_wstrb),   64'(0));
    check("rst_wlast",   64'(m_axi_wlast),   64'(0));
    check("rst_wvalid",  64'(m_axi_wvalid),  64'(0));
    check("rst_bready",  64'(m_axi_bready),  64'(0));
    check("rst_busy",    64'(busy_o),        64'(0));
    check("rst_done",    64'(done_o),        64'(0));
    check("rst_err",     64'(err_o),         64'(0));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(negedge clk_i);

    // 6-param zero-wait, then 4-param started back-to-back in the done cycle.
    run_burst(1'b1, 32'h1000_0000, 32'h1000_0000, xw, 0, 0, 2'b00, 0, 0, 0, 8);
    run_burst(1'b0, 32'h2000_0013, 32'h2000_0010, xw, 0, 0, 2'b00, 0, 0, 0, 6);
    idle_check(3, 1'b0);

    // Random stalls, AW accepted only after all W beats.
    for (int k = 0; k < 6; k++) rw[k] = {$urandom, $urandom};
    run_burst(1'b1, 32'h3000_007F, 32'h3000_0040, rw, 1, 1, 2'b00, 0, 0, 0, -1);
    idle_check(2, 1'b0);
    for (int k = 0; k < 6; k++) rw[k] = {$urandom, $urandom};
    run_burst(1'b0, 32'h3000_1008, 32'h3000_1010, rw, 1, 1, 2'b00, 0, 0, 0, -1);
    idle_check(2, 1'b0);

    // SLVERR: sticky until the next accepted start.
    run_burst(1'b0, 32'h4000_0000, 32'h4000_0010, xw, 0, 0, 2'b10, 0, 0, 0, 6);
    idle_check(3, 1'b1);
    run_burst(1'b1, 32'h4000_0040, 32'h4000_0040, xw, 0, 0, 2'b00, 0, 0, 0, 8);
    idle_check(2, 1'b0);

    // Starts during BURST and RESP are ignored; inputs change after accept.
    run_burst(1'b1, 32'h6000_0000, 32'h6000_0000, xw, 0, 0, 2'b00, 2, 1, 0, 10);
    idle_check(4, 1'b0);

    // Reset after beat 3, then a fresh complete burst.
    run_burst(1'b1, 32'h7000_0000, 32'h7000_0000, xw, 0, 0, 2'b00, 0, 0, 3, -1);
    run_burst(1'b1, 32'h7000_0080, 32'h7000_0080, xw, 0, 0, 2'b00, 0, 0, 0, 8);
    idle_check(2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
